// File: rtl/hc_sched_if.sv
// Bus bundle for hc_sched: channel requests/samples in, grants, threshold and
// per-channel comparator results out.
interface hc_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = $clog2(NCH)
);
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] ts1_flat;
  logic [NCH*DW-1:0] ts2_flat;
  logic [NCH-1:0]    ack;
  logic              th_wr;
  logic [DW-1:0]     th_din;
  logic [DW-1:0]     th_cur;
  logic [NCH-1:0]    out;
  logic              res_valid;
  logic [CW-1:0]     res_ch;
  logic              res_out;
  logic              busy;

  // The scheduler itself.
  modport slave (
    input  req, ts1_flat, ts2_flat, th_wr, th_din,
    output ack, th_cur, out, res_valid, res_ch, res_out, busy
  );

  // Sample producers and downstream consumers.
  modport master (
    output req, ts1_flat, ts2_flat, th_wr, th_din,
    input  ack, th_cur, out, res_valid, res_ch, res_out, busy
  );
endinterface

// File: rtl/hc_sched.sv
// Round-robin scheduler sharing one hysteresis comparator among NCH channels;
// grant in IDLE, evaluate in EVAL, one result every two cycles.
module hc_sched #(
  parameter int NCH        = 4,
  parameter int DW         = 8,
  parameter int TH_DEFAULT = 5,
  parameter int CW         = $clog2(NCH)
) (
  input  logic       clk,
  input  logic       rst,
  hc_sched_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   g_q;
  logic [DW-1:0]   ts1_q;
  logic [DW-1:0]   ts2_q;
  logic [DW-1:0]   th_q;
  logic [DW-1:0]   th_reg;
  logic [NCH-1:0]  out_reg;
  logic [NCH-1:0]  ack_reg;
  logic            res_valid_reg;
  logic [CW-1:0]   res_ch_reg;
  logic            res_out_reg;
  logic            busy_reg;

  logic [CW-1:0]   g_sel;
  logic            found;
  logic [CW-1:0]   ptr_next;

  logic signed [DW+1:0] diff;
  logic signed [DW+1:0] ndiff;
  logic signed [DW+1:0] th_ext;
  logic                 cur_bit;
  logic                 new_bit;

  // Rotating priority: first pending channel at or after ptr, wrapping.
  always_comb begin
    g_sel = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % NCH]) begin
        g_sel = CW'((int'(ptr) + k) % NCH);
        found = 1'b1;
      end
    end
    ptr_next = (g_sel == CW'(NCH - 1)) ? '0 : g_sel + CW'(1);
  end

  // Two guard bits keep both the difference and its negation exact at the
  // extremes, and let the unsigned threshold compare as a positive value.
  always_comb begin
    diff    = {{2{ts1_q[DW-1]}}, ts1_q} - {{2{ts2_q[DW-1]}}, ts2_q};
    ndiff   = -diff;
    th_ext  = {2'b00, th_q};
    cur_bit = out_reg[g_q];
    new_bit = cur_bit ? !(ndiff > th_ext) : (diff > th_ext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      g_q           <= '0;
      ts1_q         <= '0;
      ts2_q         <= '0;
      th_q          <= '0;
      th_reg        <= DW'(TH_DEFAULT);
      out_reg       <= '0;
      ack_reg       <= '0;
      res_valid_reg <= 1'b0;
      res_ch_reg    <= '0;
      res_out_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      ack_reg       <= '0;
      res_valid_reg <= 1'b0;
      if (bus.th_wr)
        th_reg <= bus.th_din;
      // The grant captures th_reg before any same-edge write lands.
      case (state)
        IDLE: begin
          if (found) begin
            ack_reg  <= NCH'(1) << g_sel;
            g_q      <= g_sel;
            ts1_q    <= bus.ts1_flat[g_sel*DW +: DW];
            ts2_q    <= bus.ts2_flat[g_sel*DW +: DW];
            th_q     <= th_reg;
            ptr      <= ptr_next;
            state    <= EVAL;
            busy_reg <= 1'b1;
          end
        end
        EVAL: begin
          out_reg[g_q]  <= new_bit;
          res_valid_reg <= 1'b1;
          res_ch_reg    <= g_q;
          res_out_reg   <= new_bit;
          state         <= IDLE;
          busy_reg      <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack       = ack_reg;
  assign bus.th_cur    = th_reg;
  assign bus.out       = out_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_ch    = res_ch_reg;
  assign bus.res_out   = res_out_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_hc_sched.sv
// Directed bench for hc_sched (NCH=4, DW=8, TH_DEFAULT=5); inputs change on
// the falling edge, outputs are sampled on the falling edge.
module tb_hc_sched;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  hc_sched_if #(.NCH(4), .DW(8)) bus ();

  hc_sched #(.NCH(4), .DW(8), .TH_DEFAULT(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic apply_reset();
    bus.req    = '0;
    bus.th_wr  = 1'b0;
    bus.th_din = '0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one pair on channel ch, waits (bounded) for its grant and
  // returns what the DUT reported one cycle later.
  task automatic run_pair(input int ch, input int a, input int b,
                          output logic [3:0] ack_seen, output int ack_wait,
                          output logic rv_at_ack, output logic rv,
                          output logic [1:0] rc, output logic ro);
    @(negedge clk);
    bus.ts1_flat[ch*8 +: 8] = 8'(a);
    bus.ts2_flat[ch*8 +: 8] = 8'(b);
    bus.req[ch] = 1'b1;
    ack_seen  = '0;
    ack_wait  = 0;
    rv_at_ack = 1'b0;
    while (ack_wait < 20) begin
      @(negedge clk);
      ack_wait++;
      if (bus.ack != 4'b0000) begin
        ack_seen  = bus.ack;
        rv_at_ack = bus.res_valid;
        break;
      end
    end
    bus.req[ch] = 1'b0;
    @(negedge clk);
    rv = bus.res_valid;
    rc = bus.res_ch;
    ro = bus.res_out;
  endtask

  task automatic test_reset();
    bit seen_ack;
    bit seen_rv;
    apply_reset();
    seen_ack = 1'b0;
    seen_rv  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack !== 4'b0000) seen_ack = 1'b1;
      if (bus.res_valid !== 1'b0) seen_rv = 1'b1;
    end
    n_vec++;
    if (seen_ack !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_no_ack: got ack seen=%0b expected 0", seen_ack);
    end
    n_vec++;
    if (seen_rv !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_no_res_valid: got seen=%0b expected 0", seen_rv);
    end
    n_vec++;
    if (bus.out !== 4'b0000) begin
      n_miss++;
      $display("[TB] FAIL reset_out: got %b expected 0000", bus.out);
    end
    n_vec++;
    if (bus.th_cur !== 8'd5) begin
      n_miss++;
      $display("[TB] FAIL reset_th_cur: got %0d expected 5", bus.th_cur);
    end
    n_vec++;
    if (bus.busy !== 1'b0 || bus.res_ch !== 2'd0 || bus.res_out !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL reset_misc: got busy=%b res_ch=%0d res_out=%b expected 0/0/0",
               bus.busy, bus.res_ch, bus.res_out);
    end
  endtask

  task automatic test_single_channel();
    logic [3:0] ack_seen;
    int         ack_wait;
    logic       rv_at_ack, rv, ro;
    logic [1:0] rc;
    apply_reset();
    run_pair(1, 20, 10, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (ack_seen !== 4'b0010 || ack_wait !== 1 || rv_at_ack !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL single_ack: got ack=%b wait=%0d rv=%b expected 0010/1/0",
               ack_seen, ack_wait, rv_at_ack);
    end
    n_vec++;
    if (rv !== 1'b1 || rc !== 2'd1 || ro !== 1'b1 || bus.out !== 4'b0010) begin
      n_miss++;
      $display("[TB] FAIL single_rise: got rv=%b ch=%0d ro=%b out=%b expected 1/1/1/0010",
               rv, rc, ro, bus.out);
    end
    run_pair(1, 8, 10, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (rv !== 1'b1 || ro !== 1'b1 || bus.out !== 4'b0010) begin
      n_miss++;
      $display("[TB] FAIL single_band: got rv=%b ro=%b out=%b expected 1/1/0010",
               rv, ro, bus.out);
    end
    run_pair(1, 0, 10, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (rv !== 1'b1 || rc !== 2'd1 || ro !== 1'b0 || bus.out !== 4'b0000) begin
      n_miss++;
      $display("[TB] FAIL single_fall: got rv=%b ch=%0d ro=%b out=%b expected 1/1/0/0000",
               rv, rc, ro, bus.out);
    end
  endtask

  task automatic test_boundary();
    logic [3:0] ack_seen;
    int         ack_wait;
    logic       rv_at_ack, rv, ro;
    logic [1:0] rc;
    apply_reset();
    run_pair(0, 15, 10, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (rv !== 1'b1 || ro !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL bound_eq_th_up: got rv=%b ro=%b expected 1/0", rv, ro);
    end
    run_pair(0, 127, -128, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (ro !== 1'b1 || bus.out !== 4'b0001) begin
      n_miss++;
      $display("[TB] FAIL bound_max_pos: got ro=%b out=%b expected 1/0001", ro, bus.out);
    end
    run_pair(0, 10, 15, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (ro !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL bound_eq_th_down: got ro=%b expected 1", ro);
    end
    run_pair(0, -128, 127, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (ro !== 1'b0 || bus.out !== 4'b0000) begin
      n_miss++;
      $display("[TB] FAIL bound_max_neg: got ro=%b out=%b expected 0/0000", ro, bus.out);
    end
    // Zero threshold: any strict inequality flips the state.
    @(negedge clk);
    bus.th_wr  = 1'b1;
    bus.th_din = 8'd0;
    @(negedge clk);
    bus.th_wr = 1'b0;
    run_pair(2, 1, 0, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (bus.th_cur !== 8'd0 || rc !== 2'd2 || ro !== 1'b1 || bus.out !== 4'b0100) begin
      n_miss++;
      $display("[TB] FAIL bound_th_zero: got th=%0d ch=%0d ro=%b out=%b expected 0/2/1/0100",
               bus.th_cur, rc, ro, bus.out);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    logic       exp_rv;
    apply_reset();
    bus.ts1_flat = '0;
    bus.ts2_flat = '0;
    @(negedge clk);
    bus.req = 4'b1111;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_ack = (i % 2 == 1) ? 4'(1 << (((i - 1) / 2) % 4)) : 4'b0000;
      exp_rv  = (i % 2 == 0);
      n_vec++;
      if (bus.ack !== exp_ack || bus.res_valid !== exp_rv) begin
        n_miss++;
        $display("[TB] FAIL rr_cycle%0d: got ack=%b rv=%b expected %b/%b",
                 i, bus.ack, bus.res_valid, exp_ack, exp_rv);
      end
    end
    bus.req = 4'b1001;
    @(negedge clk);
    n_vec++;
    if (bus.ack !== 4'b0001) begin
      n_miss++;
      $display("[TB] FAIL rr_wrap_ch0: got ack=%b expected 0001", bus.ack);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.ack !== 4'b1000) begin
      n_miss++;
      $display("[TB] FAIL rr_skip_to_ch3: got ack=%b expected 1000", bus.ack);
    end
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_threshold_timing();
    logic [3:0] ack_seen;
    int         ack_wait;
    logic       rv_at_ack, rv, ro;
    logic [1:0] rc;
    apply_reset();
    @(negedge clk);
    bus.ts1_flat[0 +: 8] = 8'd30;
    bus.ts2_flat[0 +: 8] = 8'd0;
    bus.req[0]  = 1'b1;
    bus.th_wr   = 1'b1;
    bus.th_din  = 8'd50;
    @(negedge clk);
    bus.req[0] = 1'b0;
    bus.th_wr  = 1'b0;
    n_vec++;
    if (bus.ack !== 4'b0001 || bus.th_cur !== 8'd50 || bus.busy !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL th_grant_edge: got ack=%b th=%0d busy=%b expected 0001/50/1",
               bus.ack, bus.th_cur, bus.busy);
    end
    @(negedge clk);
    n_vec++;
    if (bus.res_valid !== 1'b1 || bus.res_out !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL th_old_used: got rv=%b ro=%b expected 1/1",
               bus.res_valid, bus.res_out);
    end
    run_pair(1, 30, 0, ack_seen, ack_wait, rv_at_ack, rv, rc, ro);
    n_vec++;
    if (rv !== 1'b1 || rc !== 2'd1 || ro !== 1'b0 || bus.out !== 4'b0001) begin
      n_miss++;
      $display("[TB] FAIL th_new_used: got rv=%b ch=%0d ro=%b out=%b expected 1/1/0/0001",
               rv, rc, ro, bus.out);
    end
  endtask

  task automatic test_reset_mid_eval();
    bit seen_rv;
    apply_reset();
    @(negedge clk);
    bus.th_wr  = 1'b1;
    bus.th_din = 8'd77;
    @(negedge clk);
    bus.th_wr = 1'b0;
    bus.ts1_flat[16 +: 8] = 8'd100;
    bus.ts2_flat[16 +: 8] = 8'd0;
    bus.req[2] = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.ack !== 4'b0100 || bus.busy !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL mid_eval_grant: got ack=%b busy=%b expected 0100/1",
               bus.ack, bus.busy);
    end
    bus.req[2] = 1'b0;
    rst = 1'b1;
    seen_rv = 1'b0;
    @(negedge clk);
    if (bus.res_valid !== 1'b0) seen_rv = 1'b1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) seen_rv = 1'b1;
    end
    n_vec++;
    if (seen_rv !== 1'b0 || bus.out !== 4'b0000 || bus.th_cur !== 8'd5) begin
      n_miss++;
      $display("[TB] FAIL mid_eval_discard: got rv_seen=%b out=%b th=%0d expected 0/0000/5",
               seen_rv, bus.out, bus.th_cur);
    end
    bus.req = 4'b1111;
    @(negedge clk);
    n_vec++;
    if (bus.ack !== 4'b0001) begin
      n_miss++;
      $display("[TB] FAIL mid_eval_ptr: got ack=%b expected 0001", bus.ack);
    end
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    bus.req      = '0;
    bus.ts1_flat = '0;
    bus.ts2_flat = '0;
    bus.th_wr    = 1'b0;
    bus.th_din   = '0;
    rst          = 1'b1;
    test_reset();
    test_single_channel();
    test_boundary();
    test_round_robin();
    test_threshold_timing();
    test_reset_mid_eval();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
